// File: rtl/mem_read_ctrl_pkg.sv
// rtl/mem_read_ctrl_pkg.sv - shared defines: opcodes, memory read controller states and bus widths
//
// Purpose : constants shared by the load unit and the memory-read service stage.
// Contents: opcode constants, MRC_* 3-bit state encodings, default data/address widths.

package mem_read_ctrl_pkg;

    // Default bus widths
    localparam int MRC_DATA_W = 16;
    localparam int MRC_ADDR_W = 16;

    // CPU opcode constants
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;

    // Memory read controller state encodings
    localparam logic [2:0] MRC_IDLE   = 3'd0;
    localparam logic [2:0] MRC_RD     = 3'd1;
    localparam logic [2:0] MRC_VALID  = 3'd2;
    localparam logic [2:0] MRC_FINISH = 3'd3;
    localparam logic [2:0] MRC_DONE   = 3'd4;

endpackage

// File: rtl/mem_read_ctrl.sv
// rtl/mem_read_ctrl.sv - memory-read service stage between the load unit and a single-port memory
//
// Purpose : accepts a level read request with the MAR address, runs a mem_rd_en/mem_ready
//           handshake with a bounded wait, and returns the word with a valid pulse followed
//           by a finish pulse (finish+err together on timeout).
// Ports   : clk, rst_n (async, active-low)
//           read_mem_req, MAR                      - request from load unit
//           mem_addr, mem_rd_en, mem_rdata, mem_ready - memory handshake
//           in_mem_data, read_mem_valid, read_mem_finish, read_mem_err - response to load unit
//           busy                                   - high whenever not IDLE

module mem_read_ctrl
    import mem_read_ctrl_pkg::*;
#(
    parameter int ADDR_W  = MRC_ADDR_W,
    parameter int DATA_W  = MRC_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_mem_req,
    input  logic [ADDR_W-1:0] MAR,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] in_mem_data,
    output logic              read_mem_valid,
    output logic              read_mem_finish,
    output logic              read_mem_err,
    output logic              busy
);

    // Last count value before giving up; counter never passes it because timeout leaves RD.
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    logic [2:0]        state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [7:0]        cnt_q,    cnt_d;
    logic              rd_en_q,  rd_en_d;
    logic              valid_q,  valid_d;
    logic              finish_q, finish_d;
    logic              err_q,    err_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        rd_en_d  = rd_en_q;
        valid_d  = valid_q;
        finish_d = finish_q;
        err_d    = err_q;

        case (state_q)
            MRC_IDLE: begin
                if (read_mem_req) begin
                    addr_d  = MAR;
                    rd_en_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = MRC_RD;
                end
            end
            MRC_RD: begin
                // Ready takes priority over the timeout on the same edge.
                if (mem_ready) begin
                    data_d  = mem_rdata;
                    rd_en_d = 1'b0;
                    valid_d = 1'b1;
                    state_d = MRC_VALID;
                end else if (cnt_q == TIMEOUT_M1) begin
                    rd_en_d  = 1'b0;
                    err_d    = 1'b1;
                    finish_d = 1'b1;
                    state_d  = MRC_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            MRC_VALID: begin
                valid_d  = 1'b0;
                finish_d = 1'b1;
                state_d  = MRC_FINISH;
            end
            MRC_FINISH: begin
                finish_d = 1'b0;
                state_d  = MRC_DONE;
            end
            MRC_DONE: begin
                // Wait for the requester to drop its level request so a held
                // request cannot trigger a second read.
                err_d    = 1'b0;
                finish_d = 1'b0;
                if (!read_mem_req) begin
                    state_d = MRC_IDLE;
                end
            end
            default: begin
                state_d  = MRC_IDLE;
                rd_en_d  = 1'b0;
                valid_d  = 1'b0;
                finish_d = 1'b0;
                err_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MRC_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= 8'd0;
            rd_en_q  <= 1'b0;
            valid_q  <= 1'b0;
            finish_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            rd_en_q  <= rd_en_d;
            valid_q  <= valid_d;
            finish_q <= finish_d;
            err_q    <= err_d;
        end
    end

    assign mem_addr        = addr_q;
    assign mem_rd_en       = rd_en_q;
    assign in_mem_data     = data_q;
    assign read_mem_valid  = valid_q;
    assign read_mem_finish = finish_q;
    assign read_mem_err    = err_q;
    assign busy            = (state_q != MRC_IDLE);

endmodule

// File: doc/mem_read_ctrl.md
Name: mem_read_ctrl

Overview:
- Memory-read service stage that sits directly downstream of the CPU's load unit.
- Consumes the load unit's level request `read_mem_req` plus the address held in MAR.
- Drives a single-port memory read handshake (`mem_rd_en` / `mem_ready`).
- Returns the word on `in_mem_data` with a one-cycle `read_mem_valid` pulse, followed by a one-cycle `read_mem_finish` pulse, the exact sequence the load unit's READY state expects.

Parameters:
- ADDR_W, 16, width of MAR and memory address bus.
- DATA_W, 16, memory word width.
- TIMEOUT, 16, max RD cycles waiting for `mem_ready` before aborting; legal range 2..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- read_mem_req  in  1  level request from load unit; dropped by requester after it sees valid.
- MAR  in  ADDR_W  read address; sampled only on request acceptance.
- mem_addr  out  ADDR_W  registered address to memory.
- mem_rd_en  out  1  memory read strobe; held until `mem_ready` or timeout.
- mem_rdata  in  DATA_W  memory read data; valid when `mem_ready`=1.
- mem_ready  in  1  memory data-ready; ignored outside RD.
- in_mem_data  out  DATA_W  registered read data to load unit; holds last captured value.
- read_mem_valid  out  1  one-cycle pulse, data on `in_mem_data` valid.
- read_mem_finish  out  1  one-cycle pulse, transaction complete.
- read_mem_err  out  1  one-cycle pulse, timeout abort, coincident with finish.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE; all outputs 0; `mem_addr`=0; `in_mem_data`=0; counter=0. Reset mid-transaction aborts immediately; no finish pulse.
- States:
  - IDLE: if `read_mem_req`=1 at clk edge: `mem_addr`<=MAR, `mem_rd_en`<=1, cnt<=0, go to RD.
  - RD, when `mem_ready`=1 at edge: `in_mem_data`<=`mem_rdata`, `mem_rd_en`<=0, valid<=1, go to VALID.
  - RD, otherwise: cnt<=cnt+1.
  - RD, when cnt==TIMEOUT-1 and `mem_ready`=0: `mem_rd_en`<=0, err<=1, finish<=1, go to DONE. `in_mem_data` is unchanged and no valid pulse is issued.
  - RD, when `mem_ready`=1 on the timeout cycle: ready wins and a normal completion follows.
  - VALID: valid<=0, finish<=1, go to FINISH.
  - FINISH: finish<=0, go to DONE.
  - DONE: err<=0, finish<=0; if `read_mem_req`=0, go to IDLE; else stay. A held request never causes a second read.
- Latency: request seen at edge E0 gives `mem_rd_en` high from E0. If `mem_ready` is sampled at edge Ek, then valid is high during [Ek,Ek+1) and finish during [Ek+1,Ek+2).
- Minimum request-to-valid latency is 2 edges, reached when `mem_ready` is high in the first RD cycle.
- Valid and finish are never high in the same cycle. Err is only ever high together with finish.
- `mem_addr` is stable from acceptance until the next acceptance. MAR changes during a transaction are ignored.
- Counter width is 8 bits. It saturates by construction because timeout exits RD.
- Back-to-back: earliest next acceptance is 1 cycle after DONE returns to IDLE.
- Outputs `mem_addr`, `mem_rd_en`, `in_mem_data`, valid, finish and err are all registered. `busy` is decoded combinationally from state.

Decomposition:
- Shared defines file: state encodings MRC_IDLE/RD/VALID/FINISH/DONE (3-bit) and the `DATA_W`/`ADDR_W` defaults. These sit alongside the existing opcode constants (OP_LOAD etc.).
- Single module; no sub-module is warranted. The timeout counter is a few lines inline.

Test Plan:
- MAR=16'h0040, req held high; memory asserts `mem_ready` with `mem_rdata`=16'hBEEF 3 cycles after `mem_rd_en` rises.
  - `mem_addr`=16'h0040; `mem_rd_en` high 3 cycles.
  - valid pulses 1 cycle with `in_mem_data`=16'hBEEF; finish pulses the next cycle; err=0.
- TIMEOUT=8, `mem_ready` never asserted.
  - `mem_rd_en` drops after 8 cycles.
  - finish and err pulse together; `in_mem_data` keeps its previous value; no valid pulse.
- Paired with the load unit executing OP_LOAD at MAR=16'h0010 with memory word 16'h1234.
  - `load_out`=16'h1234 for exactly one cycle (`is_loaded`=1); the controller returns to IDLE.
- Req held high through DONE for 5 cycles, then dropped for 1 cycle and raised with MAR=16'h0020.
  - Exactly one read of 0x0040 occurs, followed by a read of 0x0020.
- `rst_n` pulsed low while in RD.
  - All outputs go to 0 asynchronously; no finish pulse; state is IDLE after release.
- `mem_ready` first asserted on the timeout cycle (cnt==TIMEOUT-1) with data 16'hA5A5.
  - Normal valid with 16'hA5A5 then finish; err=0.
